idex_operand_stage: RTL

- ID/EX pipeline register plus EX-side operand forwarding and load-use hazard detection for the 5-stage RV32I core.
- Captures decoded fields each cycle and resolves RAW hazards from the MEM and WB stages.
- Drives operand_a, operand_b and alu_op straight into the ALU.
- Raises a stall request toward IF/ID on load-use conflicts and inserts bubbles on stall or flush.

---
 rtl/idex_operand_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use stall detection.
// Bubbles (flush/stall) are captured in place of the decode slot; there is no register enable.
module idex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RF_AW-1:0] id_rs1_addr,
    input  logic [RF_AW-1:0] id_rs2_addr,
    input  logic [RF_AW-1:0] id_rd_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_rd_wren,
    input  logic             id_is_load,
    input  logic [3:0]       id_alu_op,
    input  logic             id_opa_sel,
    input  logic             id_opb_sel,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_rd_wren,
    input  logic [RF_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_valid,
    input  logic             wb_rd_wren,
    input  logic [RF_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]  wb_fwd_data,
    output logic             stall,
    output logic [XLEN-1:0]  operand_a,
    output logic [XLEN-1:0]  operand_b,
    output logic [3:0]       alu_op,
    output logic             ex_valid,
    output logic             ex_rd_wren,
    output logic             ex_is_load,
    output logic [RF_AW-1:0] ex_rd_addr,
    output logic [XLEN-1:0]  ex_store_data
);

    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [RF_AW-1:0] r_rs1_addr;
    logic [RF_AW-1:0] r_rs2_addr;
    logic [RF_AW-1:0] r_rd_addr;
    logic             r_use_rs1;
    logic             r_use_rs2;
    logic             r_rd_wren;
    logic             r_is_load;
    logic [3:0]       r_alu_op;
    logic             r_opa_sel;
    logic             r_opb_sel;
    logic             r_valid;

    logic             w_load_hit;
    logic             w_stall;
    logic             w_bubble;
    logic             w_mem_ok;
    logic             w_wb_ok;
    logic             w_rs1_mem;
    logic             w_rs1_wb;
    logic             w_rs2_mem;
    logic             w_rs2_wb;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // Only a load sitting in EX can cause a stall; one bubble moves it to WB for the consumer.
    assign w_load_hit = (id_use_rs1 && (id_rs1_addr == r_rd_addr)) ||
                        (id_use_rs2 && (id_rs2_addr == r_rd_addr));
    assign w_stall    = id_valid && r_valid && r_is_load && r_rd_wren &&
                        (r_rd_addr != '0) && w_load_hit;
    assign stall      = w_stall && !flush;
    assign w_bubble   = flush || w_stall;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_use_rs1  <= 1'b0;
            r_use_rs2  <= 1'b0;
            r_rd_wren  <= 1'b0;
            r_is_load  <= 1'b0;
            r_alu_op   <= 4'b0000;
            r_opa_sel  <= 1'b0;
            r_opb_sel  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd_addr  <= id_rd_addr;
            r_use_rs1  <= id_use_rs1;
            r_use_rs2  <= id_use_rs2;
            r_rd_wren  <= id_rd_wren;
            r_is_load  <= id_is_load;
            r_alu_op   <= id_alu_op;
            r_opa_sel  <= id_opa_sel;
            r_opb_sel  <= id_opb_sel;
            r_valid    <= id_valid;
        end
    end

    // x0 is never a forwarding source; a bubble in EX keeps its raw (zero) operands.
    assign w_mem_ok  = r_valid && mem_valid && mem_rd_wren && (mem_rd_addr != '0);
    assign w_wb_ok   = r_valid && wb_valid && wb_rd_wren && (wb_rd_addr != '0);
    assign w_rs1_mem = w_mem_ok && r_use_rs1 && (mem_rd_addr == r_rs1_addr);
    assign w_rs1_wb  = w_wb_ok  && r_use_rs1 && (wb_rd_addr == r_rs1_addr);
    assign w_rs2_mem = w_mem_ok && r_use_rs2 && (mem_rd_addr == r_rs2_addr);
    assign w_rs2_wb  = w_wb_ok  && r_use_rs2 && (wb_rd_addr == r_rs2_addr);

    assign w_fwd_rs1 = w_rs1_mem ? mem_fwd_data :
                       w_rs1_wb  ? wb_fwd_data  : r_rs1_data;
    assign w_fwd_rs2 = w_rs2_mem ? mem_fwd_data :
                       w_rs2_wb  ? wb_fwd_data  : r_rs2_data;

    assign operand_a     = r_opa_sel ? r_pc  : w_fwd_rs1;
    assign operand_b     = r_opb_sel ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alu_op        = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_rd_wren    = r_rd_wren;
    assign ex_is_load    = r_is_load;
    assign ex_rd_addr    = r_rd_addr;

endmodule
